// File: rtl/mod_exp_engine.sv
// mod_exp_engine: sequential modular exponentiation, result = base^exp mod N.
// Right-to-left square-and-multiply; each modular multiply is a bit-serial
// interleaved shift/add/reduce taking WORD_WIDTH cycles (multiplier MSB first).
// Optional feature macro: MOD_EXP_CYCLE_COUNT_EN adds the cycles_o busy-cycle count.
module mod_exp_engine #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] base_i,
    input  logic [WORD_WIDTH-1:0] exp_i,
    input  logic [WORD_WIDTH-1:0] mod_i,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [WORD_WIDTH-1:0] result_o
`ifdef MOD_EXP_CYCLE_COUNT_EN
    ,
    output logic [31:0]           cycles_o
`endif
);

    localparam int CW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_REDUCE, S_CHECK, S_MUL, S_SQR, S_FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] b_q, b_d, e_q, e_d, n_q, n_d, r_q, r_d;
    logic [WORD_WIDTH-1:0] result_q, result_d;
    logic [WORD_WIDTH:0]   acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
`ifdef MOD_EXP_CYCLE_COUNT_EN
    logic [31:0]           cyc_q, cyc_d, cycles_q, cycles_d;
`endif

    // Modular-multiply step signals: operand select, one shift/add/reduce, last-bit flag.
    logic [WORD_WIDTH-1:0] mm_x, mm_y, mm_res;
    logic [WORD_WIDTH:0]   acc_dbl, acc_add, n_ext;
    logic                  mm_last;

    // One cycle of MM(x, y): acc = 2*acc mod N, then conditionally add x mod N.
    always_comb begin
        mm_x  = WORD_WIDTH'(1);
        mm_y  = b_q;
        if (state_q == S_MUL) begin
            mm_x = b_q;
            mm_y = r_q;
        end else if (state_q == S_SQR) begin
            mm_x = b_q;
            mm_y = b_q;
        end
        n_ext   = {1'b0, n_q};
        acc_dbl = {acc_q[WORD_WIDTH-1:0], 1'b0};
        if (acc_dbl >= n_ext) acc_dbl = acc_dbl - n_ext;
        acc_add = acc_dbl;
        if (mm_y[cnt_q]) begin
            acc_add = acc_dbl + {1'b0, mm_x};
            if (acc_add >= n_ext) acc_add = acc_add - n_ext;
        end
        mm_res  = acc_add[WORD_WIDTH-1:0];
        mm_last = (cnt_q == '0);
    end

    // Next-state and datapath update for the exponentiation sequencer.
    always_comb begin
        state_d  = state_q;
        b_d      = b_q;
        e_d      = e_q;
        n_d      = n_q;
        r_d      = r_q;
        result_d = result_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
`ifdef MOD_EXP_CYCLE_COUNT_EN
        cyc_d    = (state_q != S_IDLE) ? cyc_q + 32'd1 : cyc_q;
        cycles_d = cycles_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    b_d     = base_i;
                    e_d     = exp_i;
                    n_d     = mod_i;
                    r_d     = WORD_WIDTH'(1);
                    err_d   = 1'b0;
                    acc_d   = '0;
                    cnt_d   = CW'(WORD_WIDTH - 1);
                    busy_d  = 1'b1;
                    state_d = (mod_i == '0) ? S_FINISH : S_REDUCE;
`ifdef MOD_EXP_CYCLE_COUNT_EN
                    cyc_d   = '0;
`endif
                end
            end
            S_REDUCE, S_MUL, S_SQR: begin
                acc_d = {1'b0, mm_res};
                cnt_d = cnt_q - CW'(1);
                if (mm_last) begin
                    acc_d = '0;
                    cnt_d = CW'(WORD_WIDTH - 1);
                    if (state_q == S_MUL) begin
                        r_d     = mm_res;
                        state_d = S_SQR;
                    end else begin
                        b_d     = mm_res;
                        state_d = S_CHECK;
                        if (state_q == S_SQR) e_d = e_q >> 1;
                    end
                end
            end
            S_CHECK: begin
                if (e_q == '0)    state_d = S_FINISH;
                else if (e_q[0])  state_d = S_MUL;
                else              state_d = S_SQR;
            end
            S_FINISH: begin
                // N of 0 or 1 forces result 0; otherwise r is already below N
                // unless no multiply happened, in which case r is 1 < N.
                result_d = (n_q <= WORD_WIDTH'(1)) ? '0 : r_q;
                err_d    = (n_q == '0);
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
`ifdef MOD_EXP_CYCLE_COUNT_EN
                cycles_d = cyc_q + 32'd1;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; async reset discards any operation in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            b_q      <= '0;
            e_q      <= '0;
            n_q      <= '0;
            r_q      <= '0;
            result_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef MOD_EXP_CYCLE_COUNT_EN
            cyc_q    <= '0;
            cycles_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            b_q      <= b_d;
            e_q      <= e_d;
            n_q      <= n_d;
            r_q      <= r_d;
            result_q <= result_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef MOD_EXP_CYCLE_COUNT_EN
            cyc_q    <= cyc_d;
            cycles_q <= cycles_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign result_o = result_q;
`ifdef MOD_EXP_CYCLE_COUNT_EN
    assign cycles_o = cycles_q;
`endif

endmodule

// File: tb/tb_mod_exp_engine.sv
// Directed testbench for mod_exp_engine with hand-computed expected values.
module tb_mod_exp_engine;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] base_i, exp_i, mod_i;
    logic         busy, done, err;
    logic [W-1:0] result_o;
`ifdef MOD_EXP_CYCLE_COUNT_EN
    logic [31:0]  cycles_o;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mod_exp_engine #(.WORD_WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_i   (base_i),
        .exp_i    (exp_i),
        .mod_i    (mod_i),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .result_o (result_o)
`ifdef MOD_EXP_CYCLE_COUNT_EN
        ,
        .cycles_o (cycles_o)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    endtask

    // Run one operation; glitch_at >= 0 pulses a competing start that many cycles in.
    task automatic run_op(input string tag, input logic [W-1:0] b, input logic [W-1:0] e,
                          input logic [W-1:0] m, input logic [W-1:0] exp_res,
                          input logic exp_err, input int exp_lat, input int glitch_at);
        int lat;
        bit seen;
        @(negedge clk);
        base_i = b; exp_i = e; mod_i = m; start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        base_i = 32'hDEADBEEF; exp_i = 32'h12345678; mod_i = '0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        lat  = 0;
        seen = 0;
        while (!seen && lat < 4000) begin
            if (lat == glitch_at) begin
                start = 1'b1; base_i = 32'd7; exp_i = 32'd3; mod_i = 32'd11;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (done) seen = 1;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_res"}, 64'(result_o), 64'(exp_res));
        chk({tag, "_err"}, 64'(err), 64'(exp_err));
`ifdef MOD_EXP_CYCLE_COUNT_EN
        chk({tag, "_cyc"}, 64'(cycles_o), 64'(exp_lat));
`endif
        @(posedge clk); #1;
        chk({tag, "_done1"}, 64'(done), 64'd0);
        chk({tag, "_hold"}, 64'(result_o), 64'(exp_res));
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int dcount;
        rst = 1'b1; start = 1'b0; base_i = '0; exp_i = '0; mod_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err",  64'(err),  64'd0);
        chk("rst_res",  64'(result_o), 64'd0);
`ifdef MOD_EXP_CYCLE_COUNT_EN
        chk("rst_cyc",  64'(cycles_o), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // L = 32*(1+k+pop) + k + 2
        run_op("p2e17",   32'd2,    32'd17,   32'd3233, 32'd1752, 1'b0, 263, -1);
        run_op("enc65",   32'd65,   32'd17,   32'd3233, 32'd2790, 1'b0, 263, -1);
        run_op("dec2790", 32'd2790, 32'd2753, 32'd3233, 32'd65,   1'b0, 590, -1);
        run_op("e0m7",    32'd5,    32'd0,    32'd7,    32'd1,    1'b0, 34,  -1);
        run_op("e0m1",    32'd5,    32'd0,    32'd1,    32'd0,    1'b0, 34,  -1);
        run_op("bigbase", 32'd3240, 32'd1,    32'd3233, 32'd7,    1'b0, 99,  -1);
        run_op("wide",    32'hFFFFFFFF, 32'd2, 32'hFFFFFFFB, 32'd16, 1'b0, 132, -1);
        run_op("mod0",    32'd9,    32'd5,    32'd0,    32'd0,    1'b1, 1,   -1);
        run_op("clrerr",  32'd2,    32'd17,   32'd3233, 32'd1752, 1'b0, 263, -1);
        run_op("glitch",  32'd2,    32'd17,   32'd3233, 32'd1752, 1'b0, 263, 50);

        // Reset in the middle of the first MUL (MUL begins 33 cycles after accept).
        @(negedge clk);
        base_i = 32'd2; exp_i = 32'd17; mod_i = 32'd3233; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_res",  64'(result_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        chk("mid_rst_nodone", 64'(dcount), 64'd0);
        run_op("after_rst", 32'd65, 32'd17, 32'd3233, 32'd2790, 1'b0, 263, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mod_exp_engine.md
Name: mod_exp_engine

Overview:
- Sequential modular exponentiation unit: result = base^exponent mod modulus, right-to-left square-and-multiply.
- Each modular multiply is a bit-serial interleaved shift/add/reduce, one multiplier bit per cycle.
- Sits directly under top_level: encryption (mode 10) drives base=message_i, exponent=e_i, modulus=N_i; decryption (mode 11) drives exponent=d_i; result feeds message_o.
- Same start-pulse / done-pulse handshake as top_level.

Parameters:
WORD_WIDTH, 32, width of base, exponent, modulus and result.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request pulse; sampled only in IDLE.
- base_i  input  WORD_WIDTH  message; any value, including >= modulus.
- exp_i  input  WORD_WIDTH  exponent (e or d).
- mod_i  input  WORD_WIDTH  modulus N.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; result_o and err valid in that cycle.
- err  output  1  set with done when mod_i==0; held until next accepted start.
- result_o  output  WORD_WIDTH  base^exp mod N; held until next accepted start.

Behaviour:
- Reset (async, any state including mid-operation):
  - State to IDLE.
  - busy=0, done=0, err=0, result_o=0, internal registers 0.
  - Operation in progress is discarded; no done pulse.
- IDLE, start=1:
  - Latch base_i, exp_i and mod_i into b, e and N.
  - Clear err and set r=1.
  - If mod_i==0: go to FINISH with err=1 and result 0.
  - Otherwise go to REDUCE.
- start while busy is ignored. Inputs may change freely after the accepting edge.
- Modular multiply MM(x, y): WORD_WIDTH cycles, acc = x*y mod N.
  - acc starts at 0; y is scanned MSB first.
  - Each cycle: acc = 2*acc; if acc>=N then acc-=N; if current y bit is 1 then acc+=x, and if acc>=N then acc-=N.
  - Datapath is WORD_WIDTH+1 bits; no overflow, since acc<N before each step.
- REDUCE (WORD_WIDTH cycles): b = MM(1, base) = base mod N. Valid for any base. Then go to CHECK.
- CHECK (1 cycle):
  - If e==0: go to FINISH with result = r mod N (N==1 gives 0).
  - Else if e[0]==1: go to MUL.
  - Else: go to SQR.
- MUL (WORD_WIDTH cycles): r = MM(b, r). Then go to SQR.
- SQR (WORD_WIDTH cycles): b = MM(b, b); e = e>>1. Then go to CHECK. The square is always performed, including after the top bit.
- FINISH (1 cycle): load result_o, pulse done, drop busy, return to IDLE.
- A new start is accepted in the cycle right after done.
- Latency, counted from the start-sampling edge to the edge that raises done:
  - L = WORD_WIDTH*(1 + k + popcount(exp)) + k + 2, where k = bit length of exp (k=0 for exp=0).
  - mod_i==0: L = 1.
- Result is always < N.

Optional Feature:
- Macro: MOD_EXP_CYCLE_COUNT_EN.
- Defined:
  - Adds output cycles_o, 32 bits, reset 0.
  - Counts cycles while busy.
  - Loaded into cycles_o on done and held until the next accepted start.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- base=2, exp=17, mod=3233 -> result_o=1752, err=0, done one cycle, L=263.
- base=65, exp=17, mod=3233 -> 2790; then base=2790, exp=2753, mod=3233 -> 65 (round trip).
- base=5, exp=0, mod=7 -> 1, L=34; base=5, exp=0, mod=1 -> 0.
- base=3240, exp=1, mod=3233 -> 7; base=0xFFFFFFFF, exp=2, mod=0xFFFFFFFB -> 16.
- mod=0 -> done at L=1, err=1, result_o=0; next valid start clears err.
- Second start pulse while busy -> ignored, first result unchanged.
- rst asserted mid-MUL -> busy=0 immediately, no done; a fresh start afterwards gives the correct result.
- With MOD_EXP_CYCLE_COUNT_EN defined: cycles_o matches the L formula for each of the cases above.
